// File: rtl/softplus_sched_pkg.sv
// rtl/softplus_sched_pkg.sv - shared types, constants and round-robin pick helper for softplus_sched
package softplus_sched_pkg;

  localparam int FP16_W   = 16;
  localparam int NREQ_MAX = 16;
  localparam int ID_MAX_W = $clog2(NREQ_MAX);

  // Tag that travels alongside an operand through the softplus pipeline
  typedef struct packed {
    logic                v;
    logic [ID_MAX_W-1:0] id;
  } sp_tag_t;

  typedef struct packed {
    logic                found;
    logic [ID_MAX_W-1:0] idx;
  } rr_pick_t;

  // First set bit at or after ptr, wrapping. Lanes above the real requester
  // count are tied low, so wrapping over NREQ_MAX equals wrapping over NREQ.
  function automatic rr_pick_t rr_pick(input logic [NREQ_MAX-1:0] valid,
                                       input logic [ID_MAX_W-1:0] ptr);
    rr_pick_t            r;
    logic [ID_MAX_W-1:0] k;
    r = '0;
    // Walk from the farthest offset down so the nearest one is kept last
    for (int i = NREQ_MAX - 1; i >= 0; i--) begin
      k = ptr + ID_MAX_W'(i);
      if (valid[k]) begin
        r.found = 1'b1;
        r.idx   = k;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/softplus_sched_fifo.sv
// rtl/softplus_sched_fifo.sv - first-word-fall-through result FIFO (sp_result_fifo)
module sp_result_fifo #(
  parameter  int W     = 18,
  parameter  int DEPTH = 32,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  // A pop frees the slot a same-cycle push needs, so push at full is fine then
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  // Output reads zero while empty so the stream data is clean after reset
  assign dout_o  = empty_o ? '0 : mem_q[rd_q];

  // Storage array, no reset needed since reads are masked while empty
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= ptr_inc(wr_q);
      if (do_pop)  rd_q <= ptr_inc(rd_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/softplus_sched.sv
// rtl/softplus_sched.sv - round-robin share of one softplus16 pipe; SOFTPLUS_SCHED_PERF_EN adds perf counters
module softplus_sched
  import softplus_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int LAT   = 24,
  parameter int DEPTH = 32,
  parameter int ID_W  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid_i,
  input  logic [NREQ*16-1:0]   req_data_i,
  output logic [NREQ-1:0]      req_ready_o,
  output logic                 sp_valid_o,
  output logic [15:0]          sp_x_o,
  input  logic                 sp_valid_i,
  input  logic [15:0]          sp_y_i,
  output logic                 rsp_valid_o,
  output logic [15:0]          rsp_data_o,
  output logic [ID_W-1:0]      rsp_id_o,
  input  logic                 rsp_ready_i,
`ifdef SOFTPLUS_SCHED_PERF_EN
  output logic [31:0]          perf_issue_o,
  output logic [31:0]          perf_stall_o,
`endif
  output logic                 err_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = ID_W + FP16_W;

  rr_pick_t            pick;
  logic [ID_W-1:0]     g;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]       credit_q, credit_d;
  logic                can_issue, accept, push, pop, drop;
  logic [FP16_W-1:0]   sel_x;
  logic                sp_valid_q;
  logic [FP16_W-1:0]   sp_x_q;
  sp_tag_t             tag_q;
  sp_tag_t             pipe_q [LAT];
  sp_tag_t             tag_out;
  logic                err_q;
  logic [FW-1:0]       fifo_dout;
  logic                fifo_full, fifo_empty;
  logic [CW-1:0]       fifo_count;
  logic                unused_sig;

  // Arbitration: grant, accept, operand select and pointer advance
  always_comb begin
    pick      = rr_pick(NREQ_MAX'(req_valid_i), ID_MAX_W'(ptr_q));
    g         = pick.idx[ID_W-1:0];
    can_issue = (credit_q < CW'(DEPTH));
    // Ready is held low during reset so nothing is taken while state is cleared
    accept    = pick.found && can_issue && !rst;
    req_ready_o = '0;
    if (accept) req_ready_o[g] = 1'b1;
    sel_x = req_data_i[int'(g)*FP16_W +: FP16_W];
    ptr_d = ptr_q;
    if (accept) ptr_d = (g == ID_W'(NREQ - 1)) ? '0 : g + 1'b1;
  end

  assign tag_out = pipe_q[LAT-1];
  assign push    = sp_valid_i && tag_out.v;
  // A tag whose result never came back still owns a credit; give it back now
  assign drop    = tag_out.v && !sp_valid_i;
  assign pop     = rsp_valid_o && rsp_ready_i;

  // Credit = operands in the pipe plus results waiting in the FIFO
  always_comb begin
    credit_d = credit_q + CW'(accept) - CW'(pop) - CW'(drop);
  end

  // Pointer, credit, issue register and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      credit_q   <= '0;
      sp_valid_q <= 1'b0;
      sp_x_q     <= '0;
      tag_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      credit_q   <= credit_d;
      sp_valid_q <= accept;
      tag_q.v    <= accept;
      if (accept) begin
        sp_x_q   <= sel_x;
        tag_q.id <= ID_MAX_W'(g);
      end
      if (sp_valid_i != tag_out.v) err_q <= 1'b1;
    end
  end

  // Tag delay line matched to the softplus16 latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_q;
      for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  sp_result_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   ({tag_out.id[ID_W-1:0], sp_y_i}),
    .pop_i   (rsp_ready_i),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign sp_valid_o  = sp_valid_q;
  assign sp_x_o      = sp_x_q;
  assign rsp_valid_o = !fifo_empty;
  assign rsp_data_o  = fifo_dout[FP16_W-1:0];
  assign rsp_id_o    = fifo_dout[FW-1:FP16_W];
  assign err_o       = err_q;
  assign unused_sig  = ^{fifo_count, fifo_full, tag_out.id, pick.idx};

`ifdef SOFTPLUS_SCHED_PERF_EN
  logic [31:0] perf_issue_q, perf_stall_q;

  // Saturating accept and credit-stall counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (accept && (perf_issue_q != '1)) perf_issue_q <= perf_issue_q + 1'b1;
      if ((|req_valid_i) && !can_issue && (perf_stall_q != '1))
        perf_stall_q <= perf_stall_q + 1'b1;
    end
  end

  assign perf_issue_o = perf_issue_q;
  assign perf_stall_o = perf_stall_q;
`endif

endmodule
